// File: rtl/stepper_pkg.sv
// Shared definitions for the stepper positioner: state codes (also the db_estado value),
// position width, timer width and direction encodings.
package stepper_pkg;
   localparam int POS_W = 16;
   localparam int TMR_W = 32;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_HOMING_HI = 3'd1;
   localparam logic [2:0] ST_HOMING_LO = 3'd2;
   localparam logic [2:0] ST_READY     = 3'd3;
   localparam logic [2:0] ST_DIR_SETUP = 3'd4;
   localparam logic [2:0] ST_STEP_HI   = 3'd5;
   localparam logic [2:0] ST_STEP_LO   = 3'd6;
   localparam logic [2:0] ST_FAULT     = 3'd7;

   function automatic logic [POS_W-1:0] clamp_pos(input logic [POS_W-1:0] pos,
                                                  input logic [POS_W-1:0] lim);
      return (pos > lim) ? lim : pos;
   endfunction
endpackage

// File: rtl/step_timer.sv
// Loadable down-counter: loading N makes o_tick go high N cycles later and stay high until reloaded.
// Times step half-periods, the direction setup window and the accel ramp.
module step_timer #(
   parameter int W = 32
) (
   input  logic         i_clock,
   input  logic         i_reset,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   output logic         o_tick
);
   logic [W-1:0] r_cnt;

   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= (i_load_val == '0) ? '0 : i_load_val - 1'b1;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_tick = (r_cnt == '0);
endmodule

// File: rtl/stepper_pos_ctrl.sv
// Step/dir positioner with homing against end_left and end-switch aborts.
// Optional STEPPER_ACCEL_EN: first step of a move at 4x half-period, ramping down to STEP_HALF.
module stepper_pos_ctrl
   import stepper_pkg::*;
#(
   parameter int unsigned STEP_HALF      = 25000,
   parameter int unsigned DIR_SETUP_CYC  = 50,
   parameter int unsigned POS_MAX        = 4000,
   parameter int unsigned HOME_MAX_STEPS = 5000
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic [POS_W-1:0] i_target_pos,
   input  logic             i_target_valid,
   input  logic             i_calib,
   input  logic             i_trava,
   input  logic             i_end_left,
   input  logic             i_end_right,
   output logic             o_step,
   output logic             o_dir,
   output logic [POS_W-1:0] o_current_pos,
   output logic             o_homed,
   output logic             o_at_target,
   output logic             o_limit_hit,
   output logic             o_fault,
   output logic [2:0]       o_db_estado
);
   localparam logic [TMR_W-1:0] HALF_T   = TMR_W'(STEP_HALF);
   localparam logic [TMR_W-1:0] SETUP_T  = TMR_W'(DIR_SETUP_CYC);
   localparam logic [POS_W-1:0] POS_LIM  = POS_W'(POS_MAX);
   localparam logic [POS_W-1:0] HOME_LIM = POS_W'(HOME_MAX_STEPS);

   logic [2:0]       r_state, w_nxt_state;
   logic             r_step, w_nxt_step;
   logic             r_dir, w_nxt_dir;
   logic [POS_W-1:0] r_pos, w_nxt_pos;
   logic [POS_W-1:0] r_target, w_nxt_target;
   logic             r_homed, w_nxt_homed;
   logic             r_at_target, w_nxt_at_target;
   logic             r_limit_hit, w_nxt_limit_hit;
   logic             r_fault, w_nxt_fault;
   logic             r_calib_pend, w_nxt_calib_pend;
   logic [POS_W-1:0] r_home_cnt, w_nxt_home_cnt;

   logic             w_tmr_load, w_tick;
   logic [TMR_W-1:0] w_tmr_val, w_step_half, w_run_half;
   logic             w_go_home, w_go_step, w_go_setup, w_go_ready, w_abort_l, w_abort_r;
   logic             w_active, w_tv, w_calib_req, w_need_move, w_req_dir;

   assign w_active    = r_state inside {ST_DIR_SETUP, ST_STEP_HI, ST_STEP_LO};
   assign w_tv        = i_target_valid & r_homed & ~i_calib & (w_active | (r_state == ST_READY));
   assign w_calib_req = i_calib | r_calib_pend;
   assign w_need_move = (r_target != r_pos);
   assign w_req_dir   = (r_target > r_pos) ? DIR_RIGHT : DIR_LEFT;

`ifdef STEPPER_ACCEL_EN
   localparam logic [TMR_W-1:0] HALF_START = TMR_W'(4 * STEP_HALF);
   localparam logic [TMR_W-1:0] HALF_DEC   = TMR_W'(STEP_HALF / 4);
   logic [TMR_W-1:0] r_half;

   // Only a step that follows a STEP_LO continues the ramp; READY/DIR_SETUP restart it.
   always_comb begin
      if (r_state != ST_STEP_LO)
         w_step_half = HALF_START;
      else if (r_half >= HALF_T + HALF_DEC)
         w_step_half = r_half - HALF_DEC;
      else
         w_step_half = HALF_T;
   end
   assign w_run_half = r_half;

   always_ff @(posedge i_clock) begin
      if (!i_reset)
         r_half <= HALF_START;
      else if (w_go_step)
         r_half <= w_step_half;
   end
`else
   assign w_step_half = HALF_T;
   assign w_run_half  = HALF_T;
`endif

   always_comb begin
      w_nxt_state      = r_state;
      w_nxt_step       = r_step;
      w_nxt_dir        = r_dir;
      w_nxt_pos        = r_pos;
      w_nxt_target     = r_target;
      w_nxt_homed      = r_homed;
      w_nxt_limit_hit  = 1'b0;
      w_nxt_fault      = r_fault;
      w_nxt_calib_pend = r_calib_pend;
      w_nxt_home_cnt   = r_home_cnt;
      w_tmr_load       = 1'b0;
      w_tmr_val        = HALF_T;
      w_go_home        = 1'b0;
      w_go_step        = 1'b0;
      w_go_setup       = 1'b0;
      w_go_ready       = 1'b0;
      w_abort_l        = 1'b0;
      w_abort_r        = 1'b0;

      if (w_tv)
         w_nxt_target = clamp_pos(i_target_pos, POS_LIM);
      if (w_active && i_calib)
         w_nxt_calib_pend = 1'b1;

      // Only the switch on the side being moved toward aborts a move.
      if (w_active) begin
         if (i_end_left && (r_dir == DIR_LEFT))
            w_abort_l = 1'b1;
         else if (i_end_right && (r_dir == DIR_RIGHT))
            w_abort_r = 1'b1;
      end

      case (r_state)
         ST_IDLE, ST_FAULT: begin
            if (i_calib) w_go_home = 1'b1;
         end
         ST_HOMING_HI: begin
            if (w_tick) begin
               w_nxt_state = ST_HOMING_LO;
               w_nxt_step  = 1'b0;
               w_tmr_load  = 1'b1;
            end
         end
         ST_HOMING_LO: begin
            if (w_tick) begin
               if (i_end_left) begin
                  w_nxt_state  = ST_READY;
                  w_nxt_pos    = '0;
                  w_nxt_target = '0;
                  w_nxt_homed  = 1'b1;
               end else if (r_home_cnt >= HOME_LIM) begin
                  w_nxt_state = ST_FAULT;
                  w_nxt_fault = 1'b1;
                  w_nxt_homed = 1'b0;
               end else begin
                  w_nxt_state    = ST_HOMING_HI;
                  w_nxt_step     = 1'b1;
                  w_nxt_home_cnt = r_home_cnt + 1'b1;
                  w_tmr_load     = 1'b1;
               end
            end
         end
         ST_READY: begin
            if (w_calib_req)
               w_go_home = 1'b1;
            else if (w_need_move && !i_trava) begin
               if (w_req_dir == r_dir) w_go_step = 1'b1;
               else                    w_go_setup = 1'b1;
            end
         end
         ST_DIR_SETUP: begin
            if (!w_abort_l && !w_abort_r && w_tick) begin
               if (w_calib_req)              w_go_home  = 1'b1;
               else if (!w_need_move)        w_go_ready = 1'b1;
               else if (w_req_dir != r_dir)  w_go_setup = 1'b1;
               else                          w_go_step  = 1'b1;
            end
         end
         ST_STEP_HI: begin
            if (!w_abort_l && !w_abort_r && w_tick) begin
               w_nxt_state = ST_STEP_LO;
               w_nxt_step  = 1'b0;
               w_tmr_load  = 1'b1;
               w_tmr_val   = w_run_half;
            end
         end
         ST_STEP_LO: begin
            if (!w_abort_l && !w_abort_r && w_tick) begin
               if (w_calib_req)              w_go_home  = 1'b1;
               else if (!w_need_move)        w_go_ready = 1'b1;
               else if (i_trava)             w_go_ready = 1'b1;
               else if (w_req_dir != r_dir)  w_go_setup = 1'b1;
               else                          w_go_step  = 1'b1;
            end
         end
         default: w_nxt_state = ST_IDLE;
      endcase

      // A step toward the left at position 0 cannot be taken; it is a left-limit abort.
      if (w_go_step) begin
         if ((r_dir == DIR_LEFT) && (r_pos == '0)) begin
            w_abort_l = 1'b1;
         end else begin
            w_nxt_state = ST_STEP_HI;
            w_nxt_step  = 1'b1;
            w_nxt_pos   = (r_dir == DIR_RIGHT) ? r_pos + 1'b1 : r_pos - 1'b1;
            w_tmr_load  = 1'b1;
            w_tmr_val   = w_step_half;
         end
      end
      if (w_go_setup) begin
         w_nxt_state = ST_DIR_SETUP;
         w_nxt_dir   = w_req_dir;
         w_tmr_load  = 1'b1;
         w_tmr_val   = SETUP_T;
      end
      if (w_go_ready) begin
         w_nxt_state = ST_READY;
         w_nxt_step  = 1'b0;
      end
      if (w_abort_l || w_abort_r) begin
         w_nxt_state     = ST_READY;
         w_nxt_step      = 1'b0;
         w_nxt_limit_hit = 1'b1;
         w_nxt_pos       = w_abort_l ? '0 : r_pos;
         w_nxt_target    = w_abort_l ? '0 : r_pos;
      end
      if (w_go_home) begin
         w_nxt_state      = ST_HOMING_HI;
         w_nxt_step       = 1'b1;
         w_nxt_dir        = DIR_LEFT;
         w_nxt_fault      = 1'b0;
         w_nxt_calib_pend = 1'b0;
         w_nxt_home_cnt   = POS_W'(1);
         w_tmr_load       = 1'b1;
         w_tmr_val        = HALF_T;
      end
   end

   assign w_nxt_at_target = (w_nxt_state == ST_READY) && (w_nxt_pos == w_nxt_target);

   step_timer #(.W(TMR_W)) u_timer (
      .i_clock    (i_clock),
      .i_reset    (i_reset),
      .i_load     (w_tmr_load),
      .i_load_val (w_tmr_val),
      .o_tick     (w_tick)
   );

   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         r_state      <= ST_IDLE;
         r_step       <= 1'b0;
         r_dir        <= DIR_LEFT;
         r_pos        <= '0;
         r_target     <= '0;
         r_homed      <= 1'b0;
         r_at_target  <= 1'b0;
         r_limit_hit  <= 1'b0;
         r_fault      <= 1'b0;
         r_calib_pend <= 1'b0;
         r_home_cnt   <= '0;
      end else begin
         r_state      <= w_nxt_state;
         r_step       <= w_nxt_step;
         r_dir        <= w_nxt_dir;
         r_pos        <= w_nxt_pos;
         r_target     <= w_nxt_target;
         r_homed      <= w_nxt_homed;
         r_at_target  <= w_nxt_at_target;
         r_limit_hit  <= w_nxt_limit_hit;
         r_fault      <= w_nxt_fault;
         r_calib_pend <= w_nxt_calib_pend;
         r_home_cnt   <= w_nxt_home_cnt;
      end
   end

   assign o_step        = r_step;
   assign o_dir         = r_dir;
   assign o_current_pos = r_pos;
   assign o_homed       = r_homed;
   assign o_at_target   = r_at_target;
   assign o_limit_hit   = r_limit_hit;
   assign o_fault       = r_fault;
   assign o_db_estado   = r_state;
endmodule

// File: tb/tb_stepper_pos_ctrl.sv
// Directed bench for stepper_pos_ctrl with a small half-period so homing, moves,
// limits, hold and fault all fit in a few thousand cycles.
module tb_stepper_pos_ctrl;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] tpos = '0;
   logic        tv = 1'b0, calib = 1'b0, trava = 1'b0, end_left = 1'b0, end_right = 1'b0;
   logic        step, dir, homed, at_target, limit_hit, fault;
   logic [15:0] pos;
   logic [2:0]  db;

   int checks = 0;
   int errors = 0;
   int pulse_total = 0, limit_total = 0;
   int hi_cnt = 0, lo_cnt = 0, last_hi = 0, last_lo = 0;
   logic prev_step = 1'b0, rise_dir = 1'b0;

   always #5 clk = ~clk;

   stepper_pos_ctrl #(
      .STEP_HALF(4), .DIR_SETUP_CYC(2), .POS_MAX(100), .HOME_MAX_STEPS(150)
   ) dut (
      .i_clock(clk), .i_reset(rst_n), .i_target_pos(tpos), .i_target_valid(tv),
      .i_calib(calib), .i_trava(trava), .i_end_left(end_left), .i_end_right(end_right),
      .o_step(step), .o_dir(dir), .o_current_pos(pos), .o_homed(homed),
      .o_at_target(at_target), .o_limit_hit(limit_hit), .o_fault(fault), .o_db_estado(db)
   );

   // Pulse bookkeeping: count rising edges, record pulse high/low widths and dir at each rise.
   always @(posedge clk) begin
      #1;
      if (step && !prev_step) begin
         pulse_total++;
         rise_dir = dir;
         last_lo  = lo_cnt;
         hi_cnt   = 1;
      end else if (step) begin
         hi_cnt++;
      end else if (prev_step) begin
         last_hi = hi_cnt;
         lo_cnt  = 1;
      end else begin
         lo_cnt++;
      end
      if (limit_hit) limit_total++;
      prev_step = step;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic wait_state(input logic [2:0] code, input int budget, input string tag);
      int n = 0;
      while (db !== code && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(tag, 32'(db), 32'(code));
   endtask

   task automatic wait_pos(input logic [15:0] p, input int budget, input string tag);
      int n = 0;
      while (pos !== p && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(tag, 32'(pos), 32'(p));
   endtask

   task automatic pulse_tv(input logic [15:0] p);
      tpos = p;
      tv   = 1'b1;
      @(negedge clk);
      tv   = 1'b0;
   endtask

   task automatic pulse_calib();
      calib = 1'b1;
      @(negedge clk);
      calib = 1'b0;
   endtask

   initial begin
      int base, lim0, n;
      repeat (3) @(negedge clk);
      check("rst_state", 32'(db), 0);
      check("rst_step", 32'(step), 0);
      check("rst_dir", 32'(dir), 0);
      check("rst_pos", 32'(pos), 0);
      check("rst_homed", 32'(homed), 0);
      check("rst_at_target", 32'(at_target), 0);
      check("rst_limit", 32'(limit_hit), 0);
      check("rst_fault", 32'(fault), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Target before homing is ignored
      base = pulse_total;
      pulse_tv(16'd10);
      repeat (20) @(negedge clk);
      check("unhomed_pulses", pulse_total - base, 0);
      check("unhomed_homed", 32'(homed), 0);
      check("unhomed_state", 32'(db), 0);

      // Homing: end_left raised during the 20th pulse
      base = pulse_total;
      pulse_calib();
      check("home_start_state", 32'(db), 1);
      n = 0;
      while (pulse_total - base < 20 && n < 300) begin
         @(negedge clk);
         n++;
      end
      end_left = 1'b1;
      wait_state(3'd3, 40, "home_ready");
      check("home_pulses", pulse_total - base, 20);
      check("home_dir", 32'(rise_dir), 0);
      check("home_pos", 32'(pos), 0);
      check("home_homed", 32'(homed), 1);
      check("home_at_target", 32'(at_target), 1);
      end_left = 1'b0;

      // Move to 5: dir change, 2 setup cycles, then 5 pulses of 4 high / 4 low
      base = pulse_total;
      pulse_tv(16'd5);
      check("t5_at_target_drop", 32'(at_target), 0);
      check("t5_still_ready", 32'(db), 3);
      @(negedge clk);
      check("t5_setup1", 32'(db), 4);
      check("t5_dir", 32'(dir), 1);
      @(negedge clk);
      check("t5_setup2", 32'(db), 4);
      @(negedge clk);
      check("t5_step_hi", 32'(db), 5);
      check("t5_pos_first", 32'(pos), 1);
      wait_state(3'd3, 100, "t5_ready");
      check("t5_pos", 32'(pos), 5);
      check("t5_at_target", 32'(at_target), 1);
      check("t5_pulses", pulse_total - base, 5);
      check("t5_hi_width", last_hi, 4);
      check("t5_lo_width", last_lo, 4);

      // Back to 2
      base = pulse_total;
      pulse_tv(16'd2);
      @(negedge clk);
      check("t2_setup", 32'(db), 4);
      wait_state(3'd3, 100, "t2_ready");
      check("t2_pos", 32'(pos), 2);
      check("t2_pulses", pulse_total - base, 3);
      check("t2_dir", 32'(rise_dir), 0);

      // Hold with trava at position 3, then release
      pulse_tv(16'd10);
      wait_pos(16'd3, 40, "trava_reach3");
      base = pulse_total;
      trava = 1'b1;
      wait_state(3'd3, 20, "trava_stop");
      repeat (20) @(negedge clk);
      check("trava_pos", 32'(pos), 3);
      check("trava_pulses", pulse_total - base, 0);
      check("trava_at_target", 32'(at_target), 0);
      trava = 1'b0;
      @(negedge clk);
      check("trava_resume_direct", 32'(db), 5);
      check("trava_resume_pos", 32'(pos), 4);
      wait_state(3'd3, 100, "t10_ready");
      check("t10_pos", 32'(pos), 10);

      // Target above POS_MAX is clamped
      pulse_tv(16'd300);
      check("clamp_at_target_drop", 32'(at_target), 0);
      @(negedge clk);
      check("clamp_step_hi", 32'(db), 5);
      wait_state(3'd3, 1000, "clamp_ready");
      check("clamp_pos", 32'(pos), 100);
      check("clamp_at_target", 32'(at_target), 1);

      // Moving left: end_right must be ignored
      pulse_tv(16'd40);
      @(negedge clk);
      check("left_setup", 32'(db), 4);
      lim0 = limit_total;
      end_right = 1'b1;
      repeat (30) @(negedge clk);
      end_right = 1'b0;
      check("away_switch_ignored", limit_total - lim0, 0);
      wait_state(3'd3, 700, "t40_ready");
      check("t40_pos", 32'(pos), 40);

      // Moving right: end_right at 60 aborts and truncates the pulse
      pulse_tv(16'd300);
      @(negedge clk);
      check("right_setup", 32'(db), 4);
      wait_pos(16'd60, 400, "reach60");
      end_right = 1'b1;
      @(negedge clk);
      check("abort_limit_hit", 32'(limit_hit), 1);
      check("abort_state", 32'(db), 3);
      check("abort_pos", 32'(pos), 60);
      check("abort_step_cut", 32'(step), 0);
      check("abort_at_target", 32'(at_target), 1);
      @(negedge clk);
      check("abort_limit_1cyc", 32'(limit_hit), 0);
      end_right = 1'b0;
      repeat (20) @(negedge clk);
      check("abort_stays_pos", 32'(pos), 60);
      check("abort_stays_ready", 32'(db), 3);

      // Same-cycle calib and target: homing wins; end_left already high -> one pulse
      base = pulse_total;
      tpos = 16'd80;
      tv = 1'b1;
      calib = 1'b1;
      @(negedge clk);
      tv = 1'b0;
      calib = 1'b0;
      check("calib_wins_state", 32'(db), 1);
      check("calib_wins_dir", 32'(dir), 0);
      end_left = 1'b1;
      wait_state(3'd3, 30, "rehome_ready");
      check("rehome_pulses", pulse_total - base, 1);
      check("rehome_pos", 32'(pos), 0);
      check("rehome_at_target", 32'(at_target), 1);
      end_left = 1'b0;
      repeat (30) @(negedge clk);
      check("target_dropped_pos", 32'(pos), 0);
      check("target_dropped_state", 32'(db), 3);

      // Homing budget exhausted
      base = pulse_total;
      pulse_calib();
      wait_state(3'd7, 1400, "fault_state");
      check("fault_pulses", pulse_total - base, 150);
      check("fault_flag", 32'(fault), 1);
      check("fault_homed", 32'(homed), 0);
      pulse_tv(16'd10);
      repeat (5) @(negedge clk);
      check("fault_ignores_target", 32'(db), 7);
      pulse_calib();
      check("fault_rehome_state", 32'(db), 1);
      check("fault_cleared", 32'(fault), 0);
      end_left = 1'b1;
      wait_state(3'd3, 30, "fault_rehome_ready");
      check("fault_rehome_homed", 32'(homed), 1);
      end_left = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
